// File: rtl/axe5000_reset_sequencer.sv
// Reset manager for AXE5000 Nios V systems: synchronises and debounces the reset
// buttons, accepts a software request and drives staggered active-low domain resets.
module axe5000_reset_sequencer #(
    parameter int NUM_BTN         = 1,
    parameter int NUM_DOMAINS     = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 64,
    parameter int CNT_W           = 8
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic [NUM_BTN-1:0]     btn_n,
    input  logic                   sw_reset_req,
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   all_released,
    output logic [NUM_BTN-1:0]     btn_state,
    output logic [CNT_W-1:0]       reset_count
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HLD_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
    localparam int STG_W = (STAGGER_CYCLES > 1)  ? $clog2(STAGGER_CYCLES)  : 1;

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HLD_W-1:0] HOLD_LAST = HLD_W'(HOLD_CYCLES - 1);
    localparam logic [STG_W-1:0] STG_LAST  = STG_W'(STAGGER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q   [NUM_BTN];
    logic [SYNC_STAGES-1:0] sync_d   [NUM_BTN];
    logic [DB_W-1:0]        db_cnt_q [NUM_BTN];
    logic [DB_W-1:0]        db_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0]     sample;
    logic [NUM_BTN-1:0]     btn_state_q;
    logic [NUM_BTN-1:0]     btn_state_d;
    logic                   pressed;

    state_e                 state_q;
    state_e                 state_d;
    logic [HLD_W-1:0]       hold_cnt_q;
    logic [HLD_W-1:0]       hold_cnt_d;
    logic [STG_W-1:0]       stg_cnt_q;
    logic [STG_W-1:0]       stg_cnt_d;
    logic [NUM_DOMAINS-1:0] rst_n_out_q;
    logic [NUM_DOMAINS-1:0] rst_n_out_d;
    logic                   all_released_q;
    logic                   all_released_d;
    logic [CNT_W-1:0]       reset_count_q;
    logic [CNT_W-1:0]       reset_count_d;

    // Button path: the last synchroniser stage is inverted so a pressed button reads 1.
    always_comb begin
        for (int b = 0; b < NUM_BTN; b++) begin
            sync_d[b] = {sync_q[b][SYNC_STAGES-2:0], btn_n[b]};
            sample[b] = ~sync_q[b][SYNC_STAGES-1];
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
        btn_state_d = btn_state_q;
        for (int b = 0; b < NUM_BTN; b++) begin
            db_cnt_d[b] = '0;
            if (sample[b] != btn_state_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    btn_state_d[b] = sample[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    assign pressed = |btn_state_q;

    // Domains release as a thermometer code: each step shifts in one more released bit.
    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        stg_cnt_d      = stg_cnt_q;
        rst_n_out_d    = rst_n_out_q;
        all_released_d = all_released_q;
        reset_count_d  = reset_count_q;

        case (state_q)
            ST_HOLD: begin
                rst_n_out_d    = '0;
                all_released_d = 1'b0;
                if (pressed) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d  = '0;
                    stg_cnt_d   = '0;
                    rst_n_out_d = NUM_DOMAINS'(1);
                    if (&rst_n_out_d) begin
                        state_d        = ST_RUN;
                        all_released_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HLD_W'(1);
                end
            end

            ST_RELEASE, ST_RUN: begin
                if (pressed || sw_reset_req) begin
                    state_d        = ST_HOLD;
                    hold_cnt_d     = '0;
                    stg_cnt_d      = '0;
                    rst_n_out_d    = '0;
                    all_released_d = 1'b0;
                    if (reset_count_q != '1) begin
                        reset_count_d = reset_count_q + CNT_W'(1);
                    end
                end else if (state_q == ST_RELEASE) begin
                    if (stg_cnt_q == STG_LAST) begin
                        stg_cnt_d   = '0;
                        rst_n_out_d = (rst_n_out_q << 1) | NUM_DOMAINS'(1);
                        if (&rst_n_out_d) begin
                            state_d        = ST_RUN;
                            all_released_d = 1'b1;
                        end
                    end else begin
                        stg_cnt_d = stg_cnt_q + STG_W'(1);
                    end
                end
            end

            default: begin
                state_d        = ST_HOLD;
                hold_cnt_d     = '0;
                stg_cnt_d      = '0;
                rst_n_out_d    = '0;
                all_released_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            // NOTE: the synchroniser and debounce arrays are small flop banks, not RAM, so they are reset like any other register.
            for (int b = 0; b < NUM_BTN; b++) begin
                sync_q[b]   <= '1;
                db_cnt_q[b] <= '0;
            end
            btn_state_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
            for (int b = 0; b < NUM_BTN; b++) begin
                sync_q[b]   <= sync_d[b];
                db_cnt_q[b] <= db_cnt_d[b];
            end
            btn_state_q <= btn_state_d;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q        <= ST_HOLD;
            hold_cnt_q     <= '0;
            stg_cnt_q      <= '0;
            rst_n_out_q    <= '0;
            all_released_q <= 1'b0;
            reset_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            stg_cnt_q      <= stg_cnt_d;
            rst_n_out_q    <= rst_n_out_d;
            all_released_q <= all_released_d;
            reset_count_q  <= reset_count_d;
        end
    end

    assign rst_n_out    = rst_n_out_q;
    assign all_released = all_released_q;
    assign btn_state    = btn_state_q;
    assign reset_count  = reset_count_q;

endmodule

// File: tb/tb_axe5000_reset_sequencer.sv
// Scoreboard bench for axe5000_reset_sequencer: a cycle model derived from the
// release-time formula feeds a queue that a negedge monitor drains.
module tb_axe5000_reset_sequencer;

    localparam int NUM_BTN  = 1;
    localparam int NUM_DOM  = 3;
    localparam int SYNC     = 2;
    localparam int DEB      = 8;
    localparam int HOLD     = 4;
    localparam int STAGGER  = 3;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic               clk;
    logic               reset_reset;
    logic [NUM_BTN-1:0] btn_n;
    logic               sw_reset_req;
    logic [NUM_DOM-1:0] rst_n_out;
    logic               all_released;
    logic [NUM_BTN-1:0] btn_state;
    logic [CNT_W-1:0]   reset_count;

    axe5000_reset_sequencer #(
        .NUM_BTN        (NUM_BTN),
        .NUM_DOMAINS    (NUM_DOM),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .STAGGER_CYCLES (STAGGER),
        .CNT_W          (CNT_W)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (reset_reset),
        .btn_n       (btn_n),
        .sw_reset_req(sw_reset_req),
        .rst_n_out   (rst_n_out),
        .all_released(all_released),
        .btn_state   (btn_state),
        .reset_count (reset_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int               edge_no;
        logic [NUM_DOM-1:0] rst;
        logic             all;
        logic             btn;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Model: domain k is released once (edge - anchor) >= HOLD + k*STAGGER, where the
    // anchor is the last edge that held or restarted the sequence.
    bit               hist[$];
    logic             m_btn;
    int               m_run;
    logic [NUM_DOM-1:0] m_rst;
    logic             m_all;
    int               m_cnt;
    int               edge_n;
    int               anchor;

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(1'b1);
        m_btn  = 1'b0;
        m_run  = 0;
        m_rst  = '0;
        m_all  = 1'b0;
        m_cnt  = 0;
        edge_n = 0;
        anchor = -1;
    endfunction

    function automatic void model_edge(input logic b, input logic req);
        logic pressed_pre;
        logic released_pre;
        logic smp;
        exp_t e;
        pressed_pre  = m_btn;
        released_pre = m_rst[0];
        smp = ~hist.pop_front();
        hist.push_back(b);
        if (smp != m_btn) begin
            m_run++;
            if (m_run == DEB) begin
                m_btn = smp;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        if (released_pre && (pressed_pre || req)) begin
            anchor = edge_n;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (!released_pre && pressed_pre) begin
            anchor = edge_n;
        end
        for (int k = 0; k < NUM_DOM; k++) m_rst[k] = (edge_n - anchor) >= (HOLD + k * STAGGER);
        m_all = &m_rst;
        e.edge_no = edge_n;
        e.rst     = m_rst;
        e.all     = m_all;
        e.btn     = m_btn;
        e.cnt     = CNT_W'(m_cnt);
        exp_q.push_back(e);
        edge_n++;
    endfunction

    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check($sformatf("edge%0d rst/all/btn/cnt", mon_e.edge_no),
                  {rst_n_out, all_released, btn_state, reset_count},
                  {mon_e.rst, mon_e.all, mon_e.btn, mon_e.cnt});
        end
    end

    task automatic step(input logic b, input logic req);
        btn_n        = b;
        sw_reset_req = req;
        @(posedge clk);
        model_edge(b, req);
        #1;
        sw_reset_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    task automatic run_until_rst(input logic [NUM_DOM-1:0] target, input int limit);
        for (int i = 0; i < limit && m_rst !== target; i++) step(1'b1, 1'b0);
        check($sformatf("reach_rst_%b", target), rst_n_out, target);
    endtask

    task automatic do_async_reset();
        @(negedge clk);
        #1;
        reset_reset  = 1'b1;
        btn_n        = 1'b1;
        sw_reset_req = 1'b0;
        #1;
        check("async_reset_outputs", {rst_n_out, all_released, btn_state, reset_count}, '0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int sat_exp [5] = '{1, 2, 3, 3, 3};
    int n;

    initial begin
        reset_reset  = 1'b1;
        btn_n        = 1'b1;
        sw_reset_req = 1'b0;
        model_reset();
        #1;
        check("reset_state", {rst_n_out, all_released, btn_state, reset_count}, '0);
        #20;
        @(negedge clk);
        reset_reset = 1'b0;

        // Power-up stagger.
        idle(4);
        check("powerup_edge3", rst_n_out, 3'b001);
        idle(3);
        check("powerup_edge6", rst_n_out, 3'b011);
        idle(3);
        check("powerup_edge9", {rst_n_out, all_released, reset_count}, {3'b111, 1'b1, 2'd0});

        // Short bounce never reaches the debounce threshold.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        idle(12);
        check("bounce", {rst_n_out, btn_state, reset_count}, {3'b111, 1'b0, 2'd0});

        // Long press: btn_state at t+9, reset at t+10.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        check("press_btn_t9", {btn_state, rst_n_out}, {1'b1, 3'b111});
        step(1'b0, 1'b0);
        check("press_rst_t10", {rst_n_out, reset_count}, {3'b000, 2'd1});
        for (int i = 0; i < 19; i++) step(1'b0, 1'b0);
        run_until_rst(3'b111, 60);
        check("press_release_all", {all_released, reset_count}, {1'b1, 2'd1});

        // Abort a sequence in RELEASE with a software request.
        step(1'b1, 1'b1);
        check("swreq_latency", {rst_n_out, reset_count}, {3'b000, 2'd2});
        run_until_rst(3'b001, 20);
        step(1'b1, 1'b1);
        check("abort_in_release", {rst_n_out, reset_count}, {3'b000, 2'd3});
        idle(3);
        check("abort_restart_hold", rst_n_out, 3'b000);
        idle(9);
        check("abort_full_release", {rst_n_out, all_released}, {3'b111, 1'b1});

        // Asynchronous reset mid-RELEASE.
        step(1'b1, 1'b1);
        run_until_rst(3'b011, 20);
        do_async_reset();
        idle(10);
        check("post_async_release", {rst_n_out, reset_count}, {3'b111, 2'd0});

        // Button press and request on the same edge count once.
        n = 0;
        while (m_btn == 1'b0 && n < 20) begin
            step(1'b0, 1'b0);
            n++;
        end
        step(1'b0, 1'b1);
        check("simultaneous_press_req", {rst_n_out, reset_count}, {3'b000, 2'd1});
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        run_until_rst(3'b111, 80);
        check("simultaneous_count", reset_count, 2'd1);

        // Saturation.
        do_async_reset();
        idle(12);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            check($sformatf("saturate_%0d", i), reset_count, sat_exp[i]);
            idle(12);
        end

        // Randomised traffic against the model.
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: idle($urandom_range(1, 12));
                3, 4: begin
                    n = $urandom_range(1, DEB - 1);
                    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
                    idle($urandom_range(1, 4));
                end
                5, 6: begin
                    n = $urandom_range(DEB + 1, 25);
                    for (int i = 0; i < n; i++) step(1'b0, ($urandom_range(0, 7) == 0));
                    idle($urandom_range(5, 30));
                end
                7, 8: step(1'b1, 1'b1);
                default: begin
                    if ($urandom_range(0, 3) == 0) do_async_reset();
                    else idle($urandom_range(1, 5));
                end
            endcase
        end
        idle(30);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axe5000_reset_sequencer.md
# axe5000_reset_sequencer

Parametrised reset manager for AXE5000 Nios V designs. It replaces the direct wiring of the raw user button into the Platform Designer system's active-low reset. It synchronises and debounces one or more active-low buttons and accepts a software reset request. From these it drives several active-low domain resets that assert together and release in a fixed, staggered order. It sits between the board-level clock/button pins and the Nios V system plus its peripheral domains.

## Interface

- NUM_BTN, 1: number of active-low reset buttons.
- NUM_DOMAINS, 3: number of sequenced reset outputs; domain 0 releases first.
- SYNC_STAGES, 2: synchroniser depth per button (≥2).
- DEBOUNCE_CYCLES, 250000: stable cycles required to accept a button change (10 ms at 25 MHz).
- HOLD_CYCLES, 16: minimum cycles all outputs stay asserted (≥1).
- STAGGER_CYCLES, 64: cycles between successive domain releases (≥1).
- CNT_W, 8: width of reset event counter.

- clk_clk  in  1  single clock for all logic.
- reset_reset  in  1  asynchronous, active-high reset; deassertion is synchronous to clk_clk (from the PLL-locked reset bridge).
- btn_n  in  NUM_BTN  asynchronous active-low buttons; 0 = pressed.
- sw_reset_req  in  1  synchronous single-cycle request for a full re-sequence.
- rst_n_out  out  NUM_DOMAINS  active-low domain resets.
- all_released  out  1  high while every domain is released.
- btn_state  out  NUM_BTN  debounced button state; 1 = pressed.
- reset_count  out  CNT_W  saturating count of re-sequence events.

## Operation

- Reset values: rst_n_out = 0, all_released = 0, btn_state = 0, reset_count = 0, synchroniser flops = 1, debounce counters = 0, FSM = HOLD, hold/stagger counters = 0.
- Synchroniser: each btn_n bit passes through SYNC_STAGES flops. The sample is the inverted last stage.
- Debounce, per channel:
  - If the sample differs from btn_state, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the sample still differs, btn_state toggles on that edge and the counter clears.
  - If the sample equals btn_state, the counter clears.
- pressed = OR of btn_state.
- FSM states: HOLD, RELEASE, RUN.
  - HOLD: all rst_n_out = 0. The counter increments while pressed = 0 and holds at 0 while pressed = 1.
  - HOLD exit: when the counter = HOLD_CYCLES-1 and pressed = 0, go to RELEASE and set rst_n_out[0] = 1 on that edge.
  - RELEASE: every STAGGER_CYCLES cycles, release the next domain. When rst_n_out[NUM_DOMAINS-1] rises, enter RUN and set all_released = 1 on the same edge.
  - RUN: outputs stay released.
- Re-sequence trigger: pressed = 1 or sw_reset_req = 1 while in RELEASE or RUN. On the next edge:
  - go to HOLD;
  - all rst_n_out = 0 and all_released = 0;
  - counters clear;
  - reset_count increments, saturating at 2^CNT_W-1.
- sw_reset_req in HOLD is ignored, and reset_count is unchanged.
- Simultaneous button press and sw_reset_req count as one event (+1).
- reset_reset asserted at any time, including mid-RELEASE, forces all reset values asynchronously. reset_count is cleared only by reset_reset.

## Timing

- Domain k release is relative to the first active edge after reset_reset deasserts (cycle 0): rst_n_out[k] rises at edge HOLD_CYCLES-1 + k·STAGGER_CYCLES.
- Press latency: btn_n falls before edge t and stays low. btn_state rises at edge t+SYNC_STAGES+DEBOUNCE_CYCLES-1. rst_n_out falls at the following edge.
- sw_reset_req latency is 1 cycle to assertion of all outputs.
- Pulses shorter than DEBOUNCE_CYCLES never change btn_state.
- Release after a press: once btn_state returns to 0, rst_n_out[0] rises HOLD_CYCLES edges later.
- Outputs are registered with no combinational path from inputs.

## Test plan

Parameters for all scenarios: NUM_DOMAINS=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, HOLD_CYCLES=4, STAGGER_CYCLES=3, CNT_W=2.

- Power-up: deassert reset_reset with buttons released -> rst_n_out = 001 at edge 3, 011 at edge 6, 111 and all_released = 1 at edge 9; reset_count = 0.
- Bounce: in RUN, btn_n low for 5 cycles, then high -> btn_state stays 0, rst_n_out stays 111, reset_count = 0.
- Press: in RUN, btn_n low from edge t for 30 cycles -> btn_state = 1 at t+9; rst_n_out = 000 at t+10; reset_count = 1. After btn_n returns high: btn_state = 0 eight cycles after the synchronised release, rst_n_out[0] rises 4 edges after that, and the full stagger follows.
- Abort: sw_reset_req pulse while rst_n_out = 001 in RELEASE -> rst_n_out = 000 next edge, reset_count +1, full sequence restarts with HOLD.
- Async reset mid-RELEASE: assert reset_reset at rst_n_out = 011 -> outputs 000, all_released = 0, reset_count = 0, btn_state = 0 with no clock edge.
- Saturation: 5 sw_reset_req pulses, each issued in RUN -> reset_count reads 1, 2, 3, 3, 3; simultaneous press and request increment by 1 only.
